// File: rtl/noc_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_port_arbiter
// Brief    : NoC crossbar output-port arbiter, fixed-priority or round-robin,
//            with back-to-back re-grant and optional hold-limit preemption.
// Revision : 1.0  initial release
// ============================================================================
module noc_port_arbiter #(
  parameter int N_REQ    = 5,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 0,
  parameter int ID_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             preempt
);

  localparam int PW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]    HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             pre_q, pre_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] others;
  logic             owner_req;
  logic             hold_hit;
  logic             issue;
  logic             issue_pre;
  logic             keep;
  logic             win_found;
  logic [PW-1:0]    win;

  assign owner_req = |(req & gnt_q);
  assign others    = req & ~gnt_q;
  assign hold_hit  = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);

  // Decide whether a new grant is issued this cycle and from which candidates.
  always_comb begin
    cand      = req;
    issue     = 1'b0;
    issue_pre = 1'b0;
    keep      = 1'b0;
    case (state_q)
      IDLE: issue = |req;
      GRANT: begin
        if (owner_req) begin
          if (hold_hit && (|others)) begin
            cand      = others;
            issue     = 1'b1;
            issue_pre = 1'b1;
          end else begin
            keep = 1'b1;
          end
        end else begin
          issue = |req;
        end
      end
      default: issue = |req;
    endcase
  end

  // Circular search from the pointer; fixed mode always searches from index 0.
  always_comb begin
    int j;
    j         = 0;
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = ((RR_MODE != 0) ? int'(ptr_q) : 0) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!win_found && cand[PW'(j)]) begin
        win_found = 1'b1;
        win       = PW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    id_d    = id_q;
    pre_d   = 1'b0;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (issue) begin
      state_d = GRANT;
      gnt_d   = ONE_HOT0 << win;
      valid_d = 1'b1;
      id_d    = ID_W'(win);
      pre_d   = issue_pre;
      ptr_d   = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
      hold_d  = (MAX_HOLD != 0) ? HW'(1) : '0;
    end else if (keep) begin
      if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) hold_d = hold_q + HW'(1);
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      valid_d = 1'b0;
      id_d    = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      pre_q   <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      pre_q   <= pre_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = id_q;
  assign preempt   = pre_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_port_arbiter
// Brief    : Directed self-checking bench for noc_port_arbiter in fixed,
//            round-robin and hold-limited configurations.
// Revision : 1.0  initial release
// ============================================================================
module tb_noc_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] req_fix = '0, req_rr = '0, req_hld = '0;
  logic [4:0] gnt_fix, gnt_rr, gnt_hld;
  logic       val_fix, val_rr, val_hld;
  logic [2:0] id_fix, id_rr, id_hld;
  logic       pre_fix, pre_rr, pre_hld;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  noc_port_arbiter #(.N_REQ(5), .RR_MODE(0), .MAX_HOLD(0), .ID_W(3)) u_fix (
    .clk(clk), .rst(rst), .req(req_fix), .gnt(gnt_fix),
    .gnt_valid(val_fix), .gnt_id(id_fix), .preempt(pre_fix));

  noc_port_arbiter #(.N_REQ(5), .RR_MODE(1), .MAX_HOLD(0), .ID_W(3)) u_rr (
    .clk(clk), .rst(rst), .req(req_rr), .gnt(gnt_rr),
    .gnt_valid(val_rr), .gnt_id(id_rr), .preempt(pre_rr));

  noc_port_arbiter #(.N_REQ(5), .RR_MODE(1), .MAX_HOLD(4), .ID_W(3)) u_hld (
    .clk(clk), .rst(rst), .req(req_hld), .gnt(gnt_hld),
    .gnt_valid(val_hld), .gnt_id(id_hld), .preempt(pre_hld));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_fix = '0;
    req_rr  = '0;
    req_hld = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [2:0] idx_of(input logic [4:0] g);
    idx_of = 3'd0;
    for (int b = 0; b < 5; b++) if (g[b]) idx_of = 3'(b);
  endfunction

  initial begin
    do_reset();
    check_eq("rst_gnt_fix", 32'(gnt_fix), 32'h0);
    check_eq("rst_val_rr",  32'(val_rr),  32'h0);
    check_eq("rst_id_hld",  32'(id_hld),  32'h0);
    check_eq("rst_pre_hld", 32'(pre_hld), 32'h0);

    // Fixed priority: lowest index wins, re-grant with no bubble.
    req_fix = 5'b10110;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_eq("fix_gnt1", 32'(gnt_fix), 32'h02);
      check_eq("fix_id1",  32'(id_fix),  32'h1);
      check_eq("fix_val1", 32'(val_fix), 32'h1);
    end
    req_fix = 5'b10100;
    tick();
    check_eq("fix_gnt2", 32'(gnt_fix), 32'h04);
    check_eq("fix_id2",  32'(id_fix),  32'h2);
    check_eq("fix_val2", 32'(val_fix), 32'h1);
    req_fix = '0;
    tick();
    check_eq("fix_idle", 32'(gnt_fix), 32'h0);

    // Round-robin rotation with each owner releasing after two cycles.
    do_reset();
    req_rr = 5'b11111;
    tick();
    for (int k = 0; k < 6; k++) begin
      int kk;
      kk = k % 5;
      check_eq("rr_gnt_a", 32'(gnt_rr), 32'(1 << kk));
      check_eq("rr_val_a", 32'(val_rr), 32'h1);
      req_rr[(kk + 4) % 5] = 1'b1;
      tick();
      check_eq("rr_gnt_b", 32'(gnt_rr), 32'(1 << kk));
      check_eq("rr_id_b",  32'(id_rr),  32'(kk));
      req_rr[kk] = 1'b0;
      tick();
      check_eq("rr_val_c", 32'(val_rr), 32'h1);
    end

    // Hold limit of 4 with two competing requesters.
    do_reset();
    req_hld = 5'b01001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c <= 4) begin
        check_eq("hld_gnt0", 32'(gnt_hld), 32'h01);
        check_eq("hld_pre0", 32'(pre_hld), 32'h0);
      end else if (c <= 8) begin
        check_eq("hld_gnt3", 32'(gnt_hld), 32'h08);
        check_eq("hld_pre3", 32'(pre_hld), 32'(c == 5));
      end else begin
        check_eq("hld_gnt0b", 32'(gnt_hld), 32'h01);
        check_eq("hld_pre0b", 32'(pre_hld), 32'(c == 9));
      end
    end

    // Hold limit with a sole requester never preempts.
    do_reset();
    req_hld = 5'b00100;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check_eq("sole_gnt", 32'(gnt_hld), 32'h04);
      check_eq("sole_pre", 32'(pre_hld), 32'h0);
    end

    // Asynchronous reset mid-grant, then first grant from pointer 0.
    do_reset();
    req_rr = 5'b01000;
    tick();
    check_eq("ar_pre_gnt", 32'(gnt_rr), 32'h08);
    #3 rst = 1'b0;
    #1;
    check_eq("ar_gnt", 32'(gnt_rr), 32'h0);
    check_eq("ar_val", 32'(val_rr), 32'h0);
    check_eq("ar_id",  32'(id_rr),  32'h0);
    check_eq("ar_pre", 32'(pre_rr), 32'h0);
    req_rr = 5'b11111;
    #2 rst = 1'b1;
    tick();
    check_eq("ar_first_gnt", 32'(gnt_rr), 32'h01);
    check_eq("ar_first_id",  32'(id_rr),  32'h0);

    // Sole owner 4 releases to idle.
    do_reset();
    req_rr = 5'b10000;
    tick();
    check_eq("rel_gnt4", 32'(gnt_rr), 32'h10);
    check_eq("rel_id4",  32'(id_rr),  32'h4);
    req_rr = '0;
    tick();
    check_eq("rel_gnt", 32'(gnt_rr), 32'h0);
    check_eq("rel_val", 32'(val_rr), 32'h0);
    check_eq("rel_id",  32'(id_rr),  32'h0);

    // Random requests: grant must stay one-hot or zero and consistent.
    do_reset();
    for (int c = 0; c < 150; c++) begin
      req_rr  = 5'($urandom_range(0, 31));
      req_hld = 5'($urandom_range(0, 31));
      tick();
      check_eq("inv_oh_rr",   32'($onehot0(gnt_rr)),  32'h1);
      check_eq("inv_val_rr",  32'(val_rr),  32'(|gnt_rr));
      check_eq("inv_id_rr",   32'(id_rr),   32'(idx_of(gnt_rr)));
      check_eq("inv_oh_hld",  32'($onehot0(gnt_hld)), 32'h1);
      check_eq("inv_val_hld", 32'(val_hld), 32'(|gnt_hld));
      check_eq("inv_id_hld",  32'(id_hld),  32'(idx_of(gnt_hld)));
      check_eq("inv_pre_hld", 32'(pre_hld & ~val_hld), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
